// File: rtl/cdr_loop_filter.sv
// Second-order bang-bang CDR loop filter: majority-vote decimation, proportional + saturating
// integral paths with ACQ->TRACK gain switching, wrapping phase accumulator driving the PI code.
module cdr_loop_filter #(
   parameter int PHASE_WIDTH  = 16,
   parameter int FREQ_WIDTH   = 16,
   parameter int CODE_WIDTH   = 11,
   parameter int DECIM        = 4,
   parameter int KP_SHIFT     = 4,
   parameter int KI_ACQ_SHIFT = 6,
   parameter int KI_TRK_SHIFT = 3,
   parameter int FREQ_SHIFT   = 4,
   parameter int ACQ_UPDATES  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  up,
   input  logic                  dn,
   input  logic                  en,
   input  logic                  freeze_freq,
   output logic [CODE_WIDTH-1:0] code,
   output logic                  code_upd,
   output logic [FREQ_WIDTH-1:0] freq_int,
   output logic                  freq_sat,
   output logic [1:0]            state
);
   // state | meaning
   // IDLE  | loop disabled, integrators hold, vote window parked at 0
   // ACQ   | acquisition, large integral gain, counting updates
   // TRACK | tracking, small integral gain

   localparam int VW  = $clog2(DECIM) + 2;
   localparam int WCW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int ACW = $clog2(ACQ_UPDATES + 1);
   localparam int EW  = FREQ_WIDTH + 2;

   localparam logic [WCW-1:0]         WIN_LAST    = WCW'(DECIM - 1);
   localparam logic [ACW-1:0]         ACQ_LAST    = ACW'(ACQ_UPDATES - 1);
   localparam logic [PHASE_WIDTH-1:0] KP_STEP     = PHASE_WIDTH'(2 ** KP_SHIFT);
   localparam logic signed [EW-1:0]   KI_ACQ_STEP = EW'(2 ** KI_ACQ_SHIFT);
   localparam logic signed [EW-1:0]   KI_TRK_STEP = EW'(2 ** KI_TRK_SHIFT);
   localparam logic signed [EW-1:0]   F_MAX       = {3'b000, {(FREQ_WIDTH-1){1'b1}}};
   localparam logic signed [EW-1:0]   F_MIN       = {3'b111, {(FREQ_WIDTH-1){1'b0}}};
   localparam logic [FREQ_WIDTH-1:0]  FQ_MAX      = {1'b0, {(FREQ_WIDTH-1){1'b1}}};
   localparam logic [FREQ_WIDTH-1:0]  FQ_MIN      = {1'b1, {(FREQ_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ACQ   = 2'b01,
      S_TRACK = 2'b10
   } state_t;

   state_t                        state_q;
   logic [PHASE_WIDTH-1:0]        phase_q;
   logic signed [FREQ_WIDTH-1:0]  freq_q;
   logic [WCW-1:0]                win_cnt;
   logic signed [VW-1:0]          vote_sum;
   logic [ACW-1:0]                acq_cnt;

   logic signed [VW-1:0]          pd;
   logic signed [VW-1:0]          vote_now;
   logic                          win_end;
   logic                          d_pos;
   logic                          d_neg;
   logic signed [EW-1:0]          ki_step;
   logic signed [EW-1:0]          freq_ext;
   logic signed [EW-1:0]          freq_sum;
   logic signed [FREQ_WIDTH-1:0]  freq_nxt;
   logic signed [FREQ_WIDTH-1:0]  freq_shr;
   logic signed [PHASE_WIDTH-1:0] freq_term;
   logic [PHASE_WIDTH-1:0]        phase_nxt;

   always_comb begin
      pd = '0;
      if (up && !dn)
         pd = VW'(1);
      else if (dn && !up)
         pd = '1;
      vote_now = vote_sum + pd;
      win_end  = (win_cnt == WIN_LAST);
      d_neg    = vote_now[VW-1];
      d_pos    = !vote_now[VW-1] && (vote_now != '0);

      // Widened by two bits so the sum cannot wrap before the clamp sees it
      ki_step  = (state_q == S_TRACK) ? KI_TRK_STEP : KI_ACQ_STEP;
      freq_ext = EW'(freq_q);
      freq_sum = freq_ext;
      if (d_pos)
         freq_sum = freq_ext + ki_step;
      else if (d_neg)
         freq_sum = freq_ext - ki_step;
      if (freq_sum > F_MAX)
         freq_nxt = FQ_MAX;
      else if (freq_sum < F_MIN)
         freq_nxt = FQ_MIN;
      else
         freq_nxt = freq_sum[FREQ_WIDTH-1:0];
      if (freeze_freq)
         freq_nxt = freq_q;

      // Phase uses the pre-update frequency and wraps modulo 2^PHASE_WIDTH
      freq_shr  = freq_q >>> FREQ_SHIFT;
      freq_term = PHASE_WIDTH'(freq_shr);
      phase_nxt = phase_q + freq_term;
      if (d_pos)
         phase_nxt = phase_nxt + KP_STEP;
      else if (d_neg)
         phase_nxt = phase_nxt - KP_STEP;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         phase_q  <= '0;
         freq_q   <= '0;
         win_cnt  <= '0;
         vote_sum <= '0;
         acq_cnt  <= '0;
         code_upd <= 1'b0;
      end else begin
         code_upd <= 1'b0;
         case (state_q)
            S_IDLE: begin
               win_cnt  <= '0;
               vote_sum <= '0;
               acq_cnt  <= '0;
               if (en)
                  state_q <= S_ACQ;
            end
            S_ACQ, S_TRACK: begin
               if (!en) begin
                  state_q  <= S_IDLE;
                  win_cnt  <= '0;
                  vote_sum <= '0;
               end else if (win_end) begin
                  win_cnt  <= '0;
                  vote_sum <= '0;
                  code_upd <= 1'b1;
                  freq_q   <= freq_nxt;
                  phase_q  <= phase_nxt;
                  if (state_q == S_ACQ) begin
                     if (acq_cnt == ACQ_LAST)
                        state_q <= S_TRACK;
                     else
                        acq_cnt <= acq_cnt + 1'b1;
                  end
               end else begin
                  win_cnt  <= win_cnt + 1'b1;
                  vote_sum <= vote_now;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign code     = phase_q[PHASE_WIDTH-1 -: CODE_WIDTH];
   assign freq_int = freq_q;
   assign freq_sat = (freq_q == FQ_MAX) || (freq_q == FQ_MIN);
   assign state    = state_q;

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Self-checking bench for cdr_loop_filter at default parameters, using a queue-based
// behavioural model of the vote window, integrators and mode sequencing.
module tb_cdr_loop_filter;
   logic        clk = 1'b0;
   logic        rst;
   logic        up;
   logic        dn;
   logic        en;
   logic        freeze_freq;
   logic [10:0] code;
   logic        code_upd;
   logic [15:0] freq_int;
   logic        freq_sat;
   logic [1:0]  state;
   logic [30:0] dut_vec;

   int checks   = 0;
   int failures = 0;

   int   m_phase;
   int   m_freq;
   int   m_state;
   int   m_acq;
   logic m_upd;
   int   win[$];

   always #5 clk = ~clk;

   cdr_loop_filter dut (
      .clk         (clk),
      .rst         (rst),
      .up          (up),
      .dn          (dn),
      .en          (en),
      .freeze_freq (freeze_freq),
      .code        (code),
      .code_upd    (code_upd),
      .freq_int    (freq_int),
      .freq_sat    (freq_sat),
      .state       (state)
   );

   assign dut_vec = {code, code_upd, freq_int, freq_sat, state};

   function automatic void model_reset();
      m_phase = 0;
      m_freq  = 0;
      m_state = 0;
      m_acq   = 0;
      m_upd   = 1'b0;
      win.delete();
   endfunction

   function automatic void model_clock(logic u, logic dd, logic e, logic f);
      int s;
      int d;
      int nf;
      m_upd = 1'b0;
      if (m_state == 0) begin
         if (e) begin
            m_state = 1;
            m_acq   = 0;
            win.delete();
         end
      end else if (!e) begin
         m_state = 0;
         win.delete();
      end else begin
         win.push_back((u && !dd) ? 1 : (dd && !u) ? -1 : 0);
         if (win.size() == 4) begin
            s = 0;
            foreach (win[i]) s += win[i];
            d = (s > 0) ? 1 : (s < 0) ? -1 : 0;
            m_phase = (m_phase + 16 * d + (m_freq >>> 4)) & 'hFFFF;
            if (!f) begin
               nf = m_freq + d * ((m_state == 2) ? 8 : 64);
               if (nf > 32767) nf = 32767;
               if (nf < -32768) nf = -32768;
               m_freq = nf;
            end
            m_upd = 1'b1;
            if (m_state == 1) begin
               m_acq++;
               if (m_acq == 256) m_state = 2;
            end
            win.delete();
         end
      end
   endfunction

   function automatic logic [30:0] exp_vec();
      return {11'(m_phase >> 5), m_upd, 16'(m_freq),
              (m_freq == 32767 || m_freq == -32768), 2'(m_state)};
   endfunction

   task automatic step(input logic u, input logic dd, input logic e, input logic f);
      up = u;
      dn = dd;
      en = e;
      freeze_freq = f;
      @(posedge clk);
      model_clock(u, dd, e, f);
      #1;
   endtask

   task automatic do_reset();
      up = 1'b0;
      dn = 1'b0;
      en = 1'b0;
      freeze_freq = 1'b0;
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      up = 1'b0;
      dn = 1'b0;
      en = 1'b0;
      freeze_freq = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== 31'd0) begin
         failures++;
         $display("FAIL reset_initial got=%h exp=0", dut_vec);
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (freq_int !== 16'd64 || state !== 2'd1) begin
         failures++;
         $display("FAIL reset_prerun freq=%0d state=%0d exp freq=64 state=1", freq_int, state);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dut_vec !== 31'd0) begin
         failures++;
         $display("FAIL reset_async got=%h exp=0", dut_vec);
      end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      step(1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (state !== 2'd1 || code_upd !== 1'b0) begin
         failures++;
         $display("FAIL basic_enter state=%0d upd=%0d exp state=1 upd=0", state, code_upd);
      end
      for (int k = 1; k <= 2; k++) begin
         for (int j = 0; j < 4; j++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            checks++;
            if (code_upd !== (j == 3) || dut_vec !== exp_vec()) begin
               failures++;
               $display("FAIL basic_step k=%0d j=%0d got=%h exp=%h", k, j, dut_vec, exp_vec());
            end
         end
         checks++;
         if (k == 1 && (freq_int !== 16'd64 || code !== 11'd0)) begin
            failures++;
            $display("FAIL basic_upd1 freq=%0d code=%0d exp freq=64 code=0", freq_int, code);
         end else if (k == 2 && (freq_int !== 16'd128 || code !== 11'd1)) begin
            failures++;
            $display("FAIL basic_upd2 freq=%0d code=%0d exp freq=128 code=1", freq_int, code);
         end
      end
   endtask

   task automatic test_zero_vote();
      logic [3:0] pu;
      logic [3:0] pdn;
      do_reset();
      step(1'b1, 1'b0, 1'b1, 1'b0);
      for (int w = 0; w < 2; w++) begin
         pu  = (w == 0) ? 4'b0011 : 4'b1111;
         pdn = (w == 0) ? 4'b1100 : 4'b1111;
         for (int j = 0; j < 4; j++) step(pu[j], pdn[j], 1'b1, 1'b0);
         checks++;
         if ({code_upd, freq_int, code} !== {1'b1, 16'd0, 11'd0}) begin
            failures++;
            $display("FAIL zero_vote w=%0d upd=%0d freq=%0d code=%0d exp upd=1 freq=0 code=0",
                     w, code_upd, freq_int, code);
         end
      end
   endtask

   task automatic test_gain_switch();
      do_reset();
      step(1'b1, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 257; k++) begin
         for (int j = 0; j < 4; j++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
               failures++;
               $display("FAIL gain_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
         end
         if (k == 255) begin
            checks++;
            if (state !== 2'd1 || freq_int !== 16'd16320) begin
               failures++;
               $display("FAIL gain_255 state=%0d freq=%0d exp state=1 freq=16320", state, freq_int);
            end
         end else if (k == 256) begin
            checks++;
            if (state !== 2'd2 || freq_int !== 16'd16384) begin
               failures++;
               $display("FAIL gain_256 state=%0d freq=%0d exp state=2 freq=16384", state, freq_int);
            end
         end else if (k == 257) begin
            checks++;
            if (state !== 2'd2 || freq_int !== 16'd16392) begin
               failures++;
               $display("FAIL gain_257 state=%0d freq=%0d exp state=2 freq=16392", state, freq_int);
            end
         end
      end
   endtask

   task automatic test_sat_wrap();
      logic [10:0] prev_code;
      logic        saw_wrap;
      prev_code = code;
      saw_wrap  = 1'b0;
      for (int k = 0; k < 2400; k++) begin
         for (int j = 0; j < 4; j++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
               failures++;
               $display("FAIL sat_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
         end
         if (code < prev_code) saw_wrap = 1'b1;
         prev_code = code;
      end
      checks++;
      if (freq_int !== 16'h7fff || freq_sat !== 1'b1) begin
         failures++;
         $display("FAIL sat_rail freq=%0d sat=%0d exp freq=32767 sat=1", freq_int, freq_sat);
      end
      checks++;
      if (saw_wrap !== 1'b1 || $isunknown(dut_vec)) begin
         failures++;
         $display("FAIL code_wrap wrapped=%0d vec=%h exp wrapped=1 no X", saw_wrap, dut_vec);
      end
   endtask

   task automatic test_modes();
      do_reset();
      step(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 4; j++) step(1'b1, 1'b0, 1'b1, 1'b1);
         checks++;
         if (freq_int !== 16'd192 || code_upd !== 1'b1 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL freeze k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
         end
      end
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         checks++;
         if (state !== 2'd0 || code_upd !== 1'b0 || freq_int !== 16'd192 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL en_drop i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
         end
      end
      step(1'b1, 1'b0, 1'b1, 1'b0);
      for (int j = 0; j < 4; j++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0);
         checks++;
         if (code_upd !== (j == 3) || state !== 2'd1) begin
            failures++;
            $display("FAIL reenable j=%0d upd=%0d state=%0d exp upd=%0d state=1",
                     j, code_upd, state, (j == 3));
         end
      end
      checks++;
      if (freq_int !== 16'd256 || dut_vec !== exp_vec()) begin
         failures++;
         $display("FAIL reenable_upd got=%h exp=%h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 40) != 0), ($urandom_range(0, 7) == 0));
         checks++;
         if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_vote();
      test_gain_switch();
      test_sat_wrap();
      test_modes();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cdr_loop_filter.md
# cdr_loop_filter

Synthesizable, parametrised second-order digital loop filter for the PMA RX clock-and-data-recovery loop. It sits between the bang-bang phase detector and the phase interpolator:
- It decimates the detector's up/dn decisions by majority vote.
- It runs proportional and integral (frequency) paths with gain switching from acquisition to tracking.
- It drives a wrapping phase-interpolator code.

It replaces the behavioural loop filter with a fully RTL, saturating, mode-aware implementation.

## Interface
Parameters:
- PHASE_WIDTH, 16, phase accumulator width (unsigned, wraps)
- FREQ_WIDTH, 16, frequency integrator width (signed, saturates)
- CODE_WIDTH, 11, output code width; code = phase_int[PHASE_WIDTH-1 -: CODE_WIDTH]; CODE_WIDTH ≤ PHASE_WIDTH
- DECIM, 4, detector samples per vote window (≥1)
- KP_SHIFT, 4, proportional gain: phase step = 2^KP_SHIFT
- KI_ACQ_SHIFT, 6, integral gain in ACQ: freq step = 2^KI_ACQ_SHIFT
- KI_TRK_SHIFT, 3, integral gain in TRACK
- FREQ_SHIFT, 4, frequency-to-phase scaling (arithmetic right shift)
- ACQ_UPDATES, 256, number of updates spent in ACQ before TRACK

Ports:
- clk  in  1  loop clock
- rst  in  1  asynchronous, active-high reset
- up  in  1  detector "early" decision
- dn  in  1  detector "late" decision
- en  in  1  loop enable
- freeze_freq  in  1  hold frequency integrator; phase path keeps running
- code  out  CODE_WIDTH  phase-interpolator code
- code_upd  out  1  one-cycle pulse: code/integrators updated at the preceding edge
- freq_int  out  FREQ_WIDTH  frequency integrator (signed), for observation
- freq_sat  out  1  freq_int at either rail
- state  out  2  00 IDLE, 01 ACQ, 10 TRACK

## Operation
- Per-cycle detector value pd:
  - +1 if up&!dn
  - −1 if dn&!up
  - 0 otherwise, including both high
- Vote window:
  - Window counter 0..DECIM-1; signed vote sum of width $clog2(DECIM)+2.
  - At the cycle with counter = DECIM-1, the resolved vote includes that cycle's pd.
  - d = sign(sum): tie gives d = 0.
  - This is an update event; the sum and counter restart.
- On an update in ACQ or TRACK:
  - freq_int_next = sat(freq_int + d·2^KI), with KI = KI_ACQ_SHIFT in ACQ and KI_TRK_SHIFT in TRACK.
  - Saturation range is [−2^(FW−1), 2^(FW−1)−1].
  - freq_int is unchanged if freeze_freq=1 or d=0.
  - phase_next = phase + d·2^KP_SHIFT + sext(freq_int >>> FREQ_SHIFT), using the pre-update freq_int, computed modulo 2^PHASE_WIDTH (wraps, never saturates).
- code_upd pulses on every update, including d=0.
- State machine:
  - IDLE→ACQ when en=1. The ACQ update counter and vote window clear on entry.
  - ACQ→TRACK at the edge of the ACQ_UPDATES-th update; that update uses ACQ gain.
  - ACQ or TRACK→IDLE whenever en=0, with priority over the transition.
  - In IDLE: integrators hold, the window counter and vote sum are held at 0, code_upd=0.
- freq_sat is combinational from freq_int.

## Timing
- All state is registered on posedge clk.
- Reset (async assert, sync deassert externally) clears:
  - phase, freq_int, code = 0
  - vote sum and counters = 0
  - state = IDLE, code_upd = 0, freq_sat = 0
- Latency: the window's last up/dn sample at edge k → new code, freq_int and code_upd=1 visible after edge k.
- First window after entering ACQ: en high at edge e makes state=ACQ after e. Window samples are taken at edges e+1..e+DECIM.
- en falling mid-window discards the partial vote. Reset mid-operation clears immediately regardless of clk.
- code wraps naturally: 2047→0 when phase crosses 2^PHASE_WIDTH.

## Test plan
- Reset: assert rst mid-run with up=1 → code, freq_int, code_upd, state all 0 without a clk edge.
- Defaults, en=1, up=1 held:
  - 1st update: freq_int=64, phase=16.
  - 2nd update: freq_int=128, phase=16+16+4=36.
  - code_upd pulses every 4 cycles.
- Window up,up,dn,dn (and separately up=dn=1 for 4 cycles) → d=0: freq_int and phase unchanged, code_upd still pulses.
- Gain switch with up=1 held → state=ACQ through update 256; freq step 64 on update 256, state=TRACK after it, freq step 8 on update 257.
- Saturation/wrap, up=1 held long → freq_int clamps at 32767 with freq_sat=1; code steps past 2047 to a small value (wrap), no X or stall.
- Modes:
  - freeze_freq=1 → freq_int constant while phase still steps by 16+(freq_int>>>4) per update.
  - en dropped after 2 samples of a window → state=IDLE, no code_upd, integrators hold.
  - Re-enable → ACQ with a fresh window and counter.
